// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer
//   Buffers operand pairs in a small FIFO and runs them one at a time through
//   an external serial adder using a start/done handshake. Results are held in
//   a one-entry output slot with a valid/ready handshake. A watchdog discards a
//   job whose adder never completes and raises a sticky error.
//
// Ports
//   clock              rising-edge clock
//   reset_n            synchronous active-low reset
//   in_valid/in_ready  operand-pair handshake
//   in_a, in_b         operand pair
//   ain, bin           operands driven to the adder (held for the whole job)
//   start              adder start request
//   done               adder completion, held high while start is high
//   sum                adder result, valid while done is high
//   out_valid/out_ready result handshake
//   out_sum            captured result
//   busy               FIFO non-empty or FSM not idle
//   err                sticky watchdog error
//   jobs_done          count of captured results (wraps at 8 bits)
module serial_add_sequencer #(
  parameter int bit_width = 8,
  parameter int depth     = 4,
  parameter int wd_limit  = 2 * bit_width + 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [bit_width-1:0] in_a,
  input  logic [bit_width-1:0] in_b,
  output logic [bit_width-1:0] ain,
  output logic [bit_width-1:0] bin,
  output logic                 start,
  input  logic                 done,
  input  logic [bit_width-1:0] sum,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [bit_width-1:0] out_sum,
  output logic                 busy,
  output logic                 err,
  output logic [7:0]           jobs_done
);

  localparam int aw  = (depth > 1) ? $clog2(depth) : 1;
  localparam int wdw = $clog2(wd_limit + 1);
  localparam logic [aw:0]    full_count = (aw + 1)'(depth);
  localparam logic [wdw-1:0] wd_last    = wdw'(wd_limit - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, RELEASE} state_t;

  state_t               state;
  logic [bit_width-1:0] fifo_a [depth];
  logic [bit_width-1:0] fifo_b [depth];
  logic [aw-1:0]        wr_ptr;
  logic [aw-1:0]        rd_ptr;
  logic [aw:0]          count;
  logic [wdw-1:0]       wd_cnt;

  logic push;
  logic pop;
  logic slot_free;
  logic capture;

  assign in_ready  = (count < full_count);
  assign push      = in_valid && in_ready;
  // A new job only launches once the adder has dropped done from the last one.
  assign pop       = (state == IDLE) && (count != '0) && !done;
  assign slot_free = !out_valid || out_ready;
  assign capture   = (state == WAIT_DONE) && done && slot_free;
  assign busy      = (count != '0) || (state != IDLE);

  // Operand storage carries no control meaning, so it is not reset.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_a[wr_ptr] <= in_a;
      fifo_b[wr_ptr] <= in_b;
    end
  end

  // FIFO pointers and occupancy; depth is a power of two so pointers wrap freely.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Job sequencer, result slot, watchdog and counters.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      start     <= 1'b0;
      ain       <= '0;
      bin       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      err       <= 1'b0;
      jobs_done <= 8'd0;
      wd_cnt    <= '0;
    end else begin
      // A capture in the same cycle as a consume refills the slot.
      if (capture) begin
        out_valid <= 1'b1;
        out_sum   <= sum;
        jobs_done <= jobs_done + 8'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pop) begin
            ain    <= fifo_a[rd_ptr];
            bin    <= fifo_b[rd_ptr];
            start  <= 1'b1;
            wd_cnt <= '0;
            state  <= LAUNCH;
          end
        end
        LAUNCH: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done) begin
            // With the slot occupied, keep start high so the adder holds sum;
            // the watchdog is frozen meanwhile.
            if (slot_free) begin
              start <= 1'b0;
              state <= RELEASE;
            end
          end else if (wd_cnt == wd_last) begin
            err   <= 1'b1;
            start <= 1'b0;
            state <= RELEASE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
module tb_serial_add_sequencer;
  localparam int LAT = 10;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic [7:0] ain, bin, sum, out_sum, jobs_done;
  logic       start, out_valid, busy, err;
  logic       done = 1'b0;
  logic       out_ready = 1'b1;
  logic       hang = 1'b0;
  int         lat_cnt = 0;

  int         checks = 0;
  int         errors = 0;
  int         exp_jobs = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_v;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] e;
  } vec_t;
  vec_t vecs[6];

  always #5 clock = ~clock;

  serial_add_sequencer #(.bit_width(8), .depth(4), .wd_limit(20)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .ain(ain), .bin(bin), .start(start), .done(done), .sum(sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .busy(busy), .err(err), .jobs_done(jobs_done)
  );

  // Behavioural serial adder: done rises LAT cycles after start, held while start.
  assign sum = ain + bin;
  always @(posedge clock) begin
    if (!reset_n || !start) begin
      lat_cnt <= 0;
      done    <= 1'b0;
    end else if (!hang) begin
      if (lat_cnt == LAT - 1) done <= 1'b1;
      else lat_cnt <= lat_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every result handshake pops the oldest expected value.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected nothing", out_sum);
      end else begin
        exp_v = sb.pop_front();
        check("result_order", {24'h0, out_sum}, {24'h0, exp_v});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] e, input bit keep);
    int n = 0;
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!acc && n < 200) begin
      @(negedge clock);
      if (in_ready) begin
        acc = 1'b1;
        if (keep) begin
          sb.push_back(e);
          exp_jobs++;
        end
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL push_accept: in_ready stayed 0 for %0d cycles, required 1", n);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clock);
    while ((sb.size() != 0 || busy || out_valid) && n < 500) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL %s: timeout busy=%0b pending=%0d, required idle", name, busy, sb.size());
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int hi;
    vecs[0] = '{8'hF0, 8'h20, 8'h10};
    vecs[1] = '{8'hFF, 8'h01, 8'h00};
    vecs[2] = '{8'h7F, 8'h80, 8'hFF};
    vecs[3] = '{8'h12, 8'h34, 8'h46};
    vecs[4] = '{8'h00, 8'h00, 8'h00};
    vecs[5] = '{8'h99, 8'h99, 8'h32};

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_start", start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_err", err, 0);
    check("rst_jobs_done", jobs_done, 0);
    check("rst_ain_bin", {ain, bin}, 0);
    step();
    reset_n = 1'b1;
    step();

    // Single job held in the slot, then consumed
    out_ready = 1'b0;
    push(8'h25, 8'h1A, 8'h3F, 1'b1);
    n = 0;
    @(negedge clock);
    while (!out_valid && n < 100) begin @(negedge clock); n++; end
    check("single_out_valid", out_valid, 1);
    check("single_out_sum", out_sum, 8'h3F);
    check("single_jobs_done", jobs_done, 1);
    n = 0;
    while (busy && n < 20) begin @(negedge clock); n++; end
    check("single_busy_falls", busy, 0);
    step();
    out_ready = 1'b1;
    wait_idle("single_drain");

    // Table of independent jobs
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].a, vecs[i].b, vecs[i].e, 1'b1);
      wait_idle("vector_idle");
    end
    check("vec_jobs_done", jobs_done, exp_jobs);
    check("vec_no_err", err, 0);

    // Backlog: 1 launched + 4 buffered fills the FIFO
    for (int i = 1; i <= 5; i++) push(8'(i), 8'(2 * i), 8'(3 * i), 1'b1);
    @(negedge clock);
    check("backlog_in_ready_low", in_ready, 0);
    check("backlog_busy", busy, 1);
    step();
    wait_idle("backlog_drain");
    check("backlog_jobs_done", jobs_done, exp_jobs);

    // Backpressure: second job must hold in WAIT_DONE past the watchdog limit
    out_ready = 1'b0;
    push(8'h11, 8'h22, 8'h33, 1'b1);
    push(8'h40, 8'h05, 8'h45, 1'b1);
    n = 0;
    @(negedge clock);
    while (!out_valid && n < 100) begin @(negedge clock); n++; end
    n = 0;
    while (!(start && done) && n < 100) begin @(negedge clock); n++; end
    check("bp_second_ain", ain, 8'h40);
    repeat (30) @(negedge clock);
    check("bp_start_held", start, 1);
    check("bp_no_err", err, 0);
    check("bp_slot_kept", out_sum, 8'h33);
    step();
    out_ready = 1'b1;
    wait_idle("bp_drain");
    check("bp_jobs_done", jobs_done, exp_jobs);

    // Watchdog: first job never completes, the queued one does
    hang = 1'b1;
    push(8'h01, 8'h01, 8'h02, 1'b0);
    push(8'h0A, 8'h0B, 8'h15, 1'b1);
    hi = 0;
    n = 0;
    @(negedge clock);
    while (!err && n < 200) begin
      if (start) hi++;
      n++;
      @(negedge clock);
    end
    hang = 1'b0;
    check("wd_err_set", err, 1);
    check("wd_start_cycles", hi, 21);
    check("wd_no_result", out_valid, 0);
    step();
    wait_idle("wd_next_job");
    check("wd_jobs_done", jobs_done, exp_jobs);
    check("wd_err_sticky", err, 1);

    // Reset in the middle of a job
    push(8'h21, 8'h12, 8'h33, 1'b1);
    push(8'h01, 8'h02, 8'h03, 1'b1);
    repeat (3) @(negedge clock);
    check("mid_start_active", start, 1);
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    sb.delete();
    exp_jobs = 0;
    @(negedge clock);
    check("mid_rst_start", start, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_sum", out_sum, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_jobs_done", jobs_done, 0);
    check("mid_rst_ain_bin", {ain, bin}, 0);
    step();
    push(8'h33, 8'h44, 8'h77, 1'b1);
    wait_idle("post_reset_job");
    check("post_reset_jobs_done", jobs_done, exp_jobs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_sequencer.md
SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

Interface
REQ-001 Parameter bit_width, default 8, operand and sum width; SHALL match the width of the downstream serial adder.
REQ-002 Parameter depth, default 4, operand FIFO entries; SHALL be a power of two and at least 2.
REQ-003 Parameter wd_limit, default 2*bit_width+4, watchdog limit in cycles for adder completion.
REQ-004 clock  in  1  single clock; all state changes on rising edge.
REQ-005 reset_n  in  1  reset is synchronous and active-low.
REQ-006 in_valid / in_ready  in / out  1 / 1  operand-pair handshake; transfer when both are high.
REQ-007 in_a, in_b  in  bit_width  operand pair.
REQ-008 ain, bin  out  bit_width  operands driven to the adder.
REQ-009 start  out  1  adder start request.
REQ-010 done  in  1  adder completion flag; held high while start is high.
REQ-011 sum  in  bit_width  adder result; valid while done=1.
REQ-012 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-013 out_sum  out  bit_width  captured result.
REQ-014 busy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE.
REQ-015 err  out  1  sticky watchdog error.
REQ-016 jobs_done  out  8  count of results captured; wraps from 255 to 0.

Function
REQ-017 FIFO: in_ready SHALL equal (count<depth); a push and a pop in the same cycle SHALL leave count unchanged; a push when full SHALL NOT occur, because in_ready is low.
REQ-018 FSM states: IDLE, LAUNCH, WAIT_DONE, RELEASE.
REQ-019 IDLE: when the FIFO is non-empty and done=0, the FSM SHALL pop the head into the ain/bin registers and go to LAUNCH the next cycle.
REQ-020 LAUNCH: start=1 with ain/bin held; the FSM SHALL go to WAIT_DONE the next cycle.
REQ-021 WAIT_DONE, entry: start SHALL stay 1 and ain/bin SHALL stay stable.
REQ-022 WAIT_DONE, capture: when done=1 and the result slot is free (out_valid=0, or out_valid=1 and out_ready=1), the block SHALL latch sum into out_sum, set out_valid, increment jobs_done, and go to RELEASE.
REQ-023 WAIT_DONE, backpressure: when done=1 and the slot is occupied, the FSM SHALL remain in WAIT_DONE with start=1, so the adder holds its result.
REQ-024 RELEASE: start=0; the FSM SHALL return to IDLE in the first cycle that done=0, so a stale done is never mistaken for a new completion.
REQ-025 Result slot: out_valid SHALL clear on out_valid&out_ready unless a capture occurs in the same cycle, in which case out_valid stays 1 with the new out_sum.
REQ-026 Throughput: at most one job is in flight; start SHALL never rise while done=1.
REQ-027 Watchdog: a counter SHALL clear on entry to LAUNCH and count each cycle in WAIT_DONE while done=0.
REQ-028 Watchdog expiry: reaching wd_limit SHALL set err, discard the job without producing a result, and go to RELEASE.
REQ-029 Watchdog hold-off: the counter SHALL NOT advance while the FSM waits on a busy result slot.
REQ-030 Arithmetic: out_sum SHALL equal the adder sum, which is (in_a+in_b) mod 2^bit_width; no carry-out is reported.
REQ-031 Ordering: results SHALL appear in the same order the operand pairs were accepted.

Reset
REQ-032 When reset_n=0 at a rising edge, the block SHALL empty the FIFO and set: FSM=IDLE, start=0, ain=bin=0, out_valid=0, out_sum=0, err=0, jobs_done=0, watchdog=0.
REQ-033 The reset-state outputs SHALL also give in_ready=1 and busy=0.
REQ-034 A reset mid-job SHALL abandon the job, including any captured but unconsumed result.
REQ-035 err SHALL clear only on reset.

Verification
REQ-036 Single job: push a=8'h25, b=8'h1A with a behavioural adder model (done 10 cycles after start) -> out_sum=8'h3F, out_valid=1, jobs_done=1, busy falls after RELEASE.
REQ-037 Wrap: push a=8'hF0, b=8'h20 -> out_sum=8'h10, no error.
REQ-038 Backlog and ordering: push 5 pairs back-to-back (a=i, b=2i, i=1..5) -> in_ready drops after 4 accepted plus 1 launched; outputs are 03, 06, 09, 0C, 0F in order.
REQ-039 Backpressure: hold out_ready=0 through two completions -> second job waits in WAIT_DONE with start=1, no err; releasing out_ready delivers both results in order.
REQ-040 Watchdog: adder never asserts done -> err=1 after wd_limit (20) WAIT_DONE cycles; the next queued job still completes correctly.
REQ-041 Reset mid-job: assert reset_n=0 for one cycle during WAIT_DONE -> all outputs return to reset values and start=0 on the next cycle.
